// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimation chain (integrators, decimator, comb).
package cic_pkg;

    localparam int CH_IDX_WIDTH      = 4;
    localparam int MAX_STAGES        = 8;
    localparam int SAMPLE_DATA_WIDTH = 37;

    // Channel-tagged sample as passed between the CIC blocks.
    typedef struct packed {
        logic                         valid;
        logic [CH_IDX_WIDTH-1:0]      chidx;
        logic [SAMPLE_DATA_WIDTH-1:0] data;
    } sample_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    function automatic bit diff_delay_legal(input int m);
        return (m == 1) || (m == 2);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One multichannel comb stage: y = x - x[n-M] per channel, with registered bypass.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int DATA_WIDTH   = 37,
    parameter int MAX_CHANNELS = 16,
    parameter int DIFF_DELAY   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic [CH_IDX_WIDTH-1:0] in_chidx,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    output logic [CH_IDX_WIDTH-1:0] out_chidx,
    output logic [DATA_WIDTH-1:0]   out_data
);

    localparam int CH_AW = (MAX_CHANNELS > 1) ? clog2(MAX_CHANNELS) : 1;

    logic [DATA_WIDTH-1:0] dly [MAX_CHANNELS][DIFF_DELAY];
    logic [CH_AW-1:0]      ch;
    logic [DATA_WIDTH-1:0] diff;

    assign ch   = in_chidx[CH_AW-1:0];
    // Read and write of the delay line share one cycle, so a same-channel
    // sample on the next cycle always sees the updated history.
    assign diff = in_data - dly[ch][DIFF_DELAY-1];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int c = 0; c < MAX_CHANNELS; c++) begin
                for (int d = 0; d < DIFF_DELAY; d++) begin
                    dly[c][d] <= '0;
                end
            end
            out_valid <= 1'b0;
            if (rst) begin
                out_chidx <= '0;
                out_data  <= '0;
            end
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_chidx <= in_chidx;
                out_data  <= en ? diff : in_data;
                if (en) begin
                    dly[ch][0] <= in_data;
                    for (int d = 1; d < DIFF_DELAY; d++) begin
                        dly[ch][d] <= dly[ch][d-1];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cic_comb_mc_pipe.sv
// Multichannel CIC comb pipeline: input gate, NUM_STAGES comb stages, narrowing register.
// Define CIC_COMB_ROUND_EN for round-half-up (saturating) narrowing instead of truncation.
module cic_comb_mc_pipe
    import cic_pkg::*;
#(
    parameter int DATA_WIDTH   = 37,
    parameter int OUT_WIDTH    = 16,
    parameter int MAX_CHANNELS = 16,
    parameter int NUM_STAGES   = 5,
    parameter int DIFF_DELAY   = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_STAGES-1:0]   cfg_stage_en,
    input  logic [4:0]              cfg_num_channels,
    input  logic                    clear_state,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [CH_IDX_WIDTH-1:0] in_chidx,
    output logic                    out_valid,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic [CH_IDX_WIDTH-1:0] out_chidx,
    output logic                    err_chidx
);

    if (!diff_delay_legal(DIFF_DELAY)) begin : g_bad_diff_delay
        $error("DIFF_DELAY must be 1 or 2");
    end
    if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES) begin : g_bad_num_stages
        $error("NUM_STAGES out of range");
    end

    logic                    chidx_ok;
    logic [NUM_STAGES:0]     st_valid;
    logic [CH_IDX_WIDTH-1:0] st_chidx [NUM_STAGES+1];
    logic [DATA_WIDTH-1:0]   st_data  [NUM_STAGES+1];
    logic [OUT_WIDTH-1:0]    narrowed;

    assign chidx_ok    = {1'b0, in_chidx} < cfg_num_channels;
    assign st_valid[0] = in_valid && chidx_ok;
    assign st_chidx[0] = in_chidx;
    assign st_data[0]  = in_data;

    always_ff @(posedge CLK) begin
        if (RST || clear_state) begin
            err_chidx <= 1'b0;
        end else if (in_valid && !chidx_ok) begin
            err_chidx <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        cic_comb_stage #(
            .DATA_WIDTH  (DATA_WIDTH),
            .MAX_CHANNELS(MAX_CHANNELS),
            .DIFF_DELAY  (DIFF_DELAY)
        ) u_stage (
            .clk      (CLK),
            .rst      (RST),
            .clear    (clear_state),
            .en       (cfg_stage_en[k]),
            .in_valid (st_valid[k]),
            .in_chidx (st_chidx[k]),
            .in_data  (st_data[k]),
            .out_valid(st_valid[k+1]),
            .out_chidx(st_chidx[k+1]),
            .out_data (st_data[k+1])
        );
    end

    if (OUT_WIDTH == DATA_WIDTH) begin : g_full_width
        assign narrowed = st_data[NUM_STAGES];
    end else begin : g_narrow
        logic [OUT_WIDTH-1:0] top_bits;
        logic                 unused_lsbs;
        assign top_bits    = st_data[NUM_STAGES][DATA_WIDTH-1 -: OUT_WIDTH];
        assign unused_lsbs = ^st_data[NUM_STAGES][DATA_WIDTH-OUT_WIDTH-1:0];
`ifdef CIC_COMB_ROUND_EN
        logic half_bit;
        assign half_bit = st_data[NUM_STAGES][DATA_WIDTH-OUT_WIDTH-1];
        // Rounding up from the largest positive code would wrap; holding the
        // top bits there is exactly the saturated value.
        assign narrowed = (half_bit && top_bits == {1'b0, {(OUT_WIDTH-1){1'b1}}})
                        ? top_bits
                        : top_bits + OUT_WIDTH'(half_bit);
`else
        assign narrowed = top_bits;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chidx <= '0;
        end else if (clear_state) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= st_valid[NUM_STAGES];
            if (st_valid[NUM_STAGES]) begin
                out_data  <= narrowed;
                out_chidx <= st_chidx[NUM_STAGES];
            end
        end
    end

endmodule
